// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register: carries writeback, memory and jump fields into MEM,
// computes EX-stage forwarding hits, and stalls on a memory request/grant handshake.
module ex_mem_pipe #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int REG_AW      = 5,
  parameter int NUM_RPORTS  = 2,
  parameter int HOLD_LEVEL  = 3,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [2:0]                   hold_flag_i,
  input  logic                         flush_i,
  input  logic                         ex_valid_i,
  input  logic [DATA_W-1:0]            reg_wdata_i,
  input  logic                         reg_we_i,
  input  logic [REG_AW-1:0]            reg_waddr_i,
  input  logic                         mem_req_i,
  input  logic                         mem_we_i,
  input  logic [ADDR_W-1:0]            mem_addr_i,
  input  logic [DATA_W-1:0]            mem_wdata_i,
  input  logic                         jump_flag_i,
  input  logic [ADDR_W-1:0]            jump_addr_i,
  input  logic [NUM_RPORTS*REG_AW-1:0] id_raddr_i,
  input  logic                         mem_gnt_i,
  output logic [NUM_RPORTS-1:0]        fwd_hit_o,
  output logic                         valid_o,
  output logic [DATA_W-1:0]            reg_wdata_o,
  output logic                         reg_we_o,
  output logic [REG_AW-1:0]            reg_waddr_o,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [ADDR_W-1:0]            mem_addr_o,
  output logic [DATA_W-1:0]            mem_wdata_o,
  output logic                         jump_flag_o,
  output logic [ADDR_W-1:0]            jump_addr_o,
  output logic                         stall_req_o,
  output logic                         mem_err_o
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT) + 1;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_GNT = 1'b1
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] reg_wdata;
    logic              reg_we;
    logic [REG_AW-1:0] reg_waddr;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              jump_flag;
    logic [ADDR_W-1:0] jump_addr;
  } stage_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  stage_t           stage_q, stage_d;
  logic             mem_err_q, mem_err_d;

  logic hold_en_s;
  logic advance_s;
  logic timeout_s;
  stage_t ex_stage_s;

  assign hold_en_s = (hold_flag_i >= 3'(HOLD_LEVEL));
  assign advance_s = ~hold_en_s & ((state_q == ST_IDLE) | mem_gnt_i);
  assign timeout_s = (state_q == ST_WAIT_GNT) & ~mem_gnt_i
                   & (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  assign ex_stage_s = '{
    valid:     1'b1,
    reg_wdata: reg_wdata_i,
    reg_we:    reg_we_i,
    reg_waddr: reg_waddr_i,
    mem_req:   mem_req_i,
    mem_we:    mem_we_i,
    mem_addr:  mem_addr_i,
    mem_wdata: mem_wdata_i,
    jump_flag: jump_flag_i,
    jump_addr: jump_addr_i
  };

  // State register: stage payload, handshake FSM, timeout counter, error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      stage_q   <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stage_q   <= stage_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Next-state logic, priority flush > timeout > advance > hold
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stage_d   = stage_q;
    mem_err_d = 1'b0;
    if (flush_i) begin
      stage_d = '0;
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (timeout_s) begin
      stage_d   = '0;
      state_d   = ST_IDLE;
      cnt_d     = '0;
      mem_err_d = 1'b1;
    end else if (advance_s) begin
      cnt_d = '0;
      if (ex_valid_i) begin
        stage_d = ex_stage_s;
        state_d = mem_req_i ? ST_WAIT_GNT : ST_IDLE;
      end else begin
        stage_d = '0;
        state_d = ST_IDLE;
      end
    end else if ((state_q == ST_WAIT_GNT) && mem_gnt_i) begin
      // granted while held: the access is done, the rest of the stage stays put
      stage_d.mem_req = 1'b0;
      state_d         = ST_IDLE;
      cnt_d           = '0;
    end else if (state_q == ST_WAIT_GNT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      state_d = state_q;
    end
  end

  // Combinational outputs: forwarding compare and stall request
  always_comb begin
    fwd_hit_o = '0;
    for (int k = 0; k < NUM_RPORTS; k++) begin
      fwd_hit_o[k] = ex_valid_i & reg_we_i & (reg_waddr_i != '0)
                   & (reg_waddr_i == id_raddr_i[k*REG_AW +: REG_AW]);
    end
    stall_req_o = (state_q == ST_WAIT_GNT) & ~mem_gnt_i;
  end

  assign valid_o     = stage_q.valid;
  assign reg_wdata_o = stage_q.reg_wdata;
  assign reg_we_o    = stage_q.reg_we;
  assign reg_waddr_o = stage_q.reg_waddr;
  assign mem_req_o   = stage_q.mem_req;
  assign mem_we_o    = stage_q.mem_we;
  assign mem_addr_o  = stage_q.mem_addr;
  assign mem_wdata_o = stage_q.mem_wdata;
  assign jump_flag_o = stage_q.jump_flag;
  assign jump_addr_o = stage_q.jump_addr;
  assign mem_err_o   = mem_err_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed-vector bench for ex_mem_pipe with hand-computed expectations.
module tb_ex_mem_pipe;

  logic        clk;
  logic        rst;
  logic [2:0]  hold_flag_i;
  logic        flush_i;
  logic        ex_valid_i;
  logic [31:0] reg_wdata_i;
  logic        reg_we_i;
  logic [4:0]  reg_waddr_i;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic [9:0]  id_raddr_i;
  logic        mem_gnt_i;
  logic [1:0]  fwd_hit_o;
  logic        valid_o;
  logic [31:0] reg_wdata_o;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic        stall_req_o;
  logic        mem_err_o;

  int n_vec;
  int n_err;

  ex_mem_pipe #(
    .DATA_W(32), .ADDR_W(32), .REG_AW(5), .NUM_RPORTS(2),
    .HOLD_LEVEL(3), .MEM_TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst), .hold_flag_i(hold_flag_i), .flush_i(flush_i),
    .ex_valid_i(ex_valid_i), .reg_wdata_i(reg_wdata_i), .reg_we_i(reg_we_i),
    .reg_waddr_i(reg_waddr_i), .mem_req_i(mem_req_i), .mem_we_i(mem_we_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .jump_flag_i(jump_flag_i),
    .jump_addr_i(jump_addr_i), .id_raddr_i(id_raddr_i), .mem_gnt_i(mem_gnt_i),
    .fwd_hit_o(fwd_hit_o), .valid_o(valid_o), .reg_wdata_o(reg_wdata_o),
    .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o),
    .stall_req_o(stall_req_o), .mem_err_o(mem_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hold_flag_i = 3'd0; flush_i = 1'b0; ex_valid_i = 1'b0;
    reg_wdata_i = 32'd0; reg_we_i = 1'b0; reg_waddr_i = 5'd0;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = 32'd0; mem_wdata_i = 32'd0;
    jump_flag_i = 1'b0; jump_addr_i = 32'd0; id_raddr_i = 10'd0; mem_gnt_i = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    check_val("rst_valid", 64'(valid_o), 64'd0);
    check_val("rst_memreq", 64'(mem_req_o), 64'd0);
    check_val("rst_err", 64'(mem_err_o), 64'd0);
    check_val("rst_stall", 64'(stall_req_o), 64'd0);
    rst = 1'b0;

    // basic valid load, then synchronous reset clears it
    ex_valid_i = 1'b1; reg_we_i = 1'b1; reg_waddr_i = 5'd5; reg_wdata_i = 32'hDEADBEEF;
    tick();
    check_val("load_valid", 64'(valid_o), 64'd1);
    check_val("load_waddr", 64'(reg_waddr_o), 64'd5);
    check_val("load_wdata", 64'(reg_wdata_o), 64'hDEADBEEF);
    check_val("load_we", 64'(reg_we_o), 64'd1);
    rst = 1'b1;
    tick();
    check_val("rst2_valid", 64'(valid_o), 64'd0);
    check_val("rst2_wdata", 64'(reg_wdata_o), 64'd0);
    check_val("rst2_waddr", 64'(reg_waddr_o), 64'd0);
    rst = 1'b0;

    // forwarding compare, combinational
    reg_waddr_i = 5'd7; reg_we_i = 1'b1; ex_valid_i = 1'b1; id_raddr_i = {5'd7, 5'd3};
    #1; check_val("fwd_hit", 64'(fwd_hit_o), 64'h2);
    id_raddr_i = {5'd7, 5'd7};
    #1; check_val("fwd_both", 64'(fwd_hit_o), 64'h3);
    reg_waddr_i = 5'd0; id_raddr_i = {5'd0, 5'd3};
    #1; check_val("fwd_x0", 64'(fwd_hit_o), 64'h0);
    reg_waddr_i = 5'd7; id_raddr_i = {5'd7, 5'd3}; reg_we_i = 1'b0;
    #1; check_val("fwd_nowe", 64'(fwd_hit_o), 64'h0);
    reg_we_i = 1'b1; ex_valid_i = 1'b0;
    #1; check_val("fwd_novalid", 64'(fwd_hit_o), 64'h0);

    // hold freezes outputs, lower hold level loads
    clear_inputs();
    ex_valid_i = 1'b1; reg_we_i = 1'b1; reg_waddr_i = 5'd9; reg_wdata_i = 32'h11111111;
    tick();
    check_val("hold_pre", 64'(reg_wdata_o), 64'h11111111);
    hold_flag_i = 3'd3; reg_waddr_i = 5'd10; reg_wdata_i = 32'h22222222;
    tick();
    check_val("hold1_wdata", 64'(reg_wdata_o), 64'h11111111);
    check_val("hold1_waddr", 64'(reg_waddr_o), 64'd9);
    hold_flag_i = 3'd7; reg_wdata_i = 32'h33333333;
    tick();
    check_val("hold2_wdata", 64'(reg_wdata_o), 64'h11111111);
    hold_flag_i = 3'd2;
    tick();
    check_val("hold_rel_wdata", 64'(reg_wdata_o), 64'h33333333);
    check_val("hold_rel_waddr", 64'(reg_waddr_o), 64'd10);

    // memory request waits for grant, then next non-mem op loads
    clear_inputs();
    ex_valid_i = 1'b1; mem_req_i = 1'b1; mem_we_i = 1'b1;
    mem_addr_i = 32'h1000; mem_wdata_i = 32'hCAFE;
    tick();
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = 32'h2000; mem_wdata_i = 32'd0;
    reg_we_i = 1'b1; reg_waddr_i = 5'd3; reg_wdata_i = 32'hABCD;
    for (int i = 0; i < 3; i++) begin
      check_val("wait_req", 64'(mem_req_o), 64'd1);
      check_val("wait_stall", 64'(stall_req_o), 64'd1);
      check_val("wait_addr", 64'(mem_addr_o), 64'h1000);
      check_val("wait_wdata", 64'(mem_wdata_o), 64'hCAFE);
      if (i < 2) tick();
    end
    mem_gnt_i = 1'b1;
    #1; check_val("gnt_stall", 64'(stall_req_o), 64'd0);
    tick();
    mem_gnt_i = 1'b0;
    check_val("gnt_req", 64'(mem_req_o), 64'd0);
    check_val("gnt_waddr", 64'(reg_waddr_o), 64'd3);
    check_val("gnt_wdata", 64'(reg_wdata_o), 64'hABCD);
    check_val("gnt_stall2", 64'(stall_req_o), 64'd0);
    check_val("gnt_err", 64'(mem_err_o), 64'd0);

    // grant while held: request drops, other fields kept
    clear_inputs();
    ex_valid_i = 1'b1; mem_req_i = 1'b1; mem_addr_i = 32'h4000; reg_waddr_i = 5'd12;
    tick();
    hold_flag_i = 3'd3; mem_gnt_i = 1'b1; mem_addr_i = 32'h4444; reg_waddr_i = 5'd13;
    tick();
    check_val("hgnt_req", 64'(mem_req_o), 64'd0);
    check_val("hgnt_addr", 64'(mem_addr_o), 64'h4000);
    check_val("hgnt_waddr", 64'(reg_waddr_o), 64'd12);
    check_val("hgnt_valid", 64'(valid_o), 64'd1);
    mem_gnt_i = 1'b0;
    #1; check_val("hgnt_stall", 64'(stall_req_o), 64'd0);

    // timeout: never granted
    clear_inputs();
    ex_valid_i = 1'b1; mem_req_i = 1'b1; mem_addr_i = 32'h3000; reg_waddr_i = 5'd4;
    tick();
    for (int i = 0; i < 4; i++) begin
      check_val("to_stall", 64'(stall_req_o), 64'd1);
      check_val("to_noerr", 64'(mem_err_o), 64'd0);
      check_val("to_req", 64'(mem_req_o), 64'd1);
      tick();
    end
    check_val("to_err", 64'(mem_err_o), 64'd1);
    check_val("to_valid", 64'(valid_o), 64'd0);
    check_val("to_req_clr", 64'(mem_req_o), 64'd0);
    check_val("to_idle", 64'(stall_req_o), 64'd0);
    mem_req_i = 1'b0; mem_addr_i = 32'd0; reg_waddr_i = 5'd6;
    tick();
    check_val("to_err_pulse", 64'(mem_err_o), 64'd0);
    check_val("to_reload", 64'(valid_o), 64'd1);
    check_val("to_reload_waddr", 64'(reg_waddr_o), 64'd6);

    // flush during WAIT_GNT
    clear_inputs();
    ex_valid_i = 1'b1; jump_flag_i = 1'b1; jump_addr_i = 32'h400;
    mem_req_i = 1'b1; mem_addr_i = 32'h5000;
    tick();
    check_val("fl_pre_jump", 64'(jump_flag_o), 64'd1);
    check_val("fl_pre_req", 64'(mem_req_o), 64'd1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check_val("fl_valid", 64'(valid_o), 64'd0);
    check_val("fl_jump", 64'(jump_flag_o), 64'd0);
    check_val("fl_jaddr", 64'(jump_addr_o), 64'd0);
    check_val("fl_req", 64'(mem_req_o), 64'd0);
    check_val("fl_err", 64'(mem_err_o), 64'd0);
    check_val("fl_stall", 64'(stall_req_o), 64'd0);
    clear_inputs();
    tick();
    check_val("fl_err_late", 64'(mem_err_o), 64'd0);
    check_val("fl_bubble", 64'(valid_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
